// File: rtl/mips_rom_loader_if.sv
// mips_rom_loader_if: byte stream, ROM write port and core control of the boot loader
interface mips_rom_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic start, in_valid, in_ready, rom_we, core_run, done, error;
  logic [7:0] in_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;
  modport master (
    output start, in_valid, in_data,
    input in_ready, rom_we, rom_addr, rom_wdata, core_run, done, error
  );
  modport slave (
    input start, in_valid, in_data,
    output in_ready, rom_we, rom_addr, rom_wdata, core_run, done, error
  );
endinterface

// File: rtl/mips_rom_loader.sv
// mips_rom_loader: loads a checksummed big-endian word image into instruction ROM, then releases the core
module mips_rom_loader #(
  parameter int ADDR_W = 8,
  parameter int MAX_WORDS = 256
) (
  input logic clk,
  input logic rst_n,
  mips_rom_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CKSUM, RUN, ERR} state_t;
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);
  state_t state;
  logic [15:0] cnt, widx, n;
  logic [1:0] bidx;
  logic [23:0] sh;
  logic [7:0] xsum;
  logic acc, last;
  assign acc = bus.in_valid && bus.in_ready;
  assign n = {cnt[15:8], bus.in_data};
  assign last = widx == cnt - 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.in_ready <= 1'b0;
      bus.rom_we <= 1'b0;
      bus.rom_addr <= '0;
      bus.rom_wdata <= '0;
      bus.core_run <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      cnt <= '0;
      widx <= '0;
      bidx <= '0;
      sh <= '0;
      xsum <= '0;
    end else begin
      bus.rom_we <= 1'b0;
      case (state)
        IDLE, RUN, ERR: if (bus.start) begin
          state <= CNT_HI;
          bus.in_ready <= 1'b1;
          bus.core_run <= 1'b0;
          bus.done <= 1'b0;
          bus.error <= 1'b0;
          xsum <= '0;
          widx <= '0;
          bidx <= '0;
        end
        CNT_HI: if (acc) begin
          cnt[15:8] <= bus.in_data;
          xsum <= xsum ^ bus.in_data;
          state <= CNT_LO;
        end
        CNT_LO: if (acc) begin
          cnt[7:0] <= bus.in_data;
          xsum <= xsum ^ bus.in_data;
          if (n == 16'd0) state <= CKSUM;
          else if ({1'b0, n} > MAXW) begin
            state <= ERR;
            bus.in_ready <= 1'b0;
            bus.error <= 1'b1;
          end else state <= DATA;
        end
        DATA: begin
          if (acc) begin
            xsum <= xsum ^ bus.in_data;
            bidx <= bidx + 2'd1;
            sh <= {sh[15:0], bus.in_data};
            if (bidx == 2'd3) begin
              bus.rom_we <= 1'b1;
              bus.rom_addr <= widx[ADDR_W-1:0];
              bus.rom_wdata <= {sh, bus.in_data};
              // stall the stream during the final write so the checksum byte lands in CKSUM
              if (last) bus.in_ready <= 1'b0;
            end
          end
          if (bus.rom_we) begin
            widx <= widx + 16'd1;
            if (last) begin
              state <= CKSUM;
              bus.in_ready <= 1'b1;
            end
          end
        end
        CKSUM: if (acc) begin
          bus.in_ready <= 1'b0;
          if (bus.in_data == xsum) begin
            state <= RUN;
            bus.core_run <= 1'b1;
            bus.done <= 1'b1;
          end else begin
            state <= ERR;
            bus.error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mips_rom_loader.sv
// tb_mips_rom_loader: directed frames against the boot loader with a ROM write monitor
module tb_mips_rom_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0, errors = 0, cyc = 0, nwr = 0, last_wr = 0, prev_wr = 0, w0 = 0;
  logic [31:0] rom [256];
  logic [31:0] img [4];
  mips_rom_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  mips_rom_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.rom_we) begin
      rom[bus.rom_addr] <= bus.rom_wdata;
      nwr <= nwr + 1;
      prev_wr <= last_wr;
      last_wr <= cyc;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    if (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask
  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
  endtask
  task automatic send_frame(input logic [15:0] n, input logic [7:0] ck, input bit gap);
    send(n[15:8], gap);
    send(n[7:0], gap);
    for (int w = 0; w < int'(n); w++)
      for (int k = 3; k >= 0; k--) send(img[w][8*k +: 8], gap);
    send(ck, gap);
    idle();
    repeat (2) @(negedge clk);
    #1;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_rom_we", 32'(bus.rom_we), 32'd0);
    check("rst_core_run", 32'(bus.core_run), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_rom_wdata", bus.rom_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    img[0] = 32'h8C01_0000;
    img[1] = 32'h8C02_0001;
    pulse_start();
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    w0 = nwr;
    send_frame(16'd2, 8'h00, 1'b0);
    check("t1_writes", 32'(nwr - w0), 32'd2);
    check("t1_rom0", rom[0], 32'h8C01_0000);
    check("t1_rom1", rom[1], 32'h8C02_0001);
    check("t1_interval", 32'(last_wr - prev_wr), 32'd4);
    check("t1_core_run", 32'(bus.core_run), 32'd1);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_error", 32'(bus.error), 32'd0);
    check("t1_in_ready", 32'(bus.in_ready), 32'd0);
    check("t1_addr_hold", 32'(bus.rom_addr), 32'd1);
    check("t1_wdata_hold", bus.rom_wdata, 32'h8C02_0001);
    pulse_start();
    w0 = nwr;
    send_frame(16'd2, 8'h5A, 1'b0);
    check("t2_writes", 32'(nwr - w0), 32'd2);
    check("t2_error", 32'(bus.error), 32'd1);
    check("t2_core_run", 32'(bus.core_run), 32'd0);
    check("t2_done", 32'(bus.done), 32'd0);
    pulse_start();
    w0 = nwr;
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    #1;
    check("t3_error", 32'(bus.error), 32'd1);
    check("t3_in_ready", 32'(bus.in_ready), 32'd0);
    check("t3_core_run", 32'(bus.core_run), 32'd0);
    check("t3_writes", 32'(nwr - w0), 32'd0);
    pulse_start();
    check("t4_error_clr", 32'(bus.error), 32'd0);
    w0 = nwr;
    send_frame(16'd0, 8'h00, 1'b0);
    check("t4_writes", 32'(nwr - w0), 32'd0);
    check("t4_core_run", 32'(bus.core_run), 32'd1);
    check("t4_done", 32'(bus.done), 32'd1);
    pulse_start();
    w0 = nwr;
    send_frame(16'd2, 8'h00, 1'b1);
    check("t5_writes", 32'(nwr - w0), 32'd2);
    check("t5_rom0", rom[0], 32'h8C01_0000);
    check("t5_rom1", rom[1], 32'h8C02_0001);
    check("t5_interval", 32'(last_wr - prev_wr), 32'd8);
    check("t5_core_run", 32'(bus.core_run), 32'd1);
    pulse_start();
    w0 = nwr;
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h8C, 1'b0);
    send(8'h01, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_core_run", 32'(bus.core_run), 32'd0);
    check("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    send_frame(16'd2, 8'h00, 1'b0);
    check("t6_writes", 32'(nwr - w0), 32'd2);
    check("t6_core_run", 32'(bus.core_run), 32'd1);
    check("t6_done", 32'(bus.done), 32'd1);
    img[0] = 32'h1234_5678;
    pulse_start();
    check("t7_core_run_drop", 32'(bus.core_run), 32'd0);
    w0 = nwr;
    send_frame(16'd1, 8'h09, 1'b0);
    check("t7_writes", 32'(nwr - w0), 32'd1);
    check("t7_rom0", rom[0], 32'h1234_5678);
    check("t7_rom1_kept", rom[1], 32'h8C02_0001);
    check("t7_core_run", 32'(bus.core_run), 32'd1);
    check("t7_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_core_run", 32'(bus.core_run), 32'd0);
    check("async_done", 32'(bus.done), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
